// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue stage: operand drive, busy hold, writeback handshake.
// Optional ISSUE_FASTPATH_EN: single-cycle ops capture in EXEC and skip WAIT.
module alu_issue_stage #(
  parameter int XLEN     = 32,
  parameter int REGW     = 5,
  parameter int MAX_WAIT = 64
) (
  input  logic            i_clk_n,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_use_imm,
  input  logic [2:0]      i_funct3,
  input  logic [6:0]      i_funct7,
  input  logic [REGW-1:0] i_rd,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [2:0]      o_alu_funct3,
  output logic [6:0]      o_alu_funct7,
  output logic            o_alu_en,
  output logic            o_alu_imm,
  input  logic            i_alu_busy,
  input  logic [XLEN-1:0] i_alu_out,
  output logic            o_wb_valid,
  input  logic            i_wb_ready,
  output logic [REGW-1:0] o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_timeout
);

  localparam int CW = $clog2(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_OUT} state_t;

  state_t          state_q;
  logic [XLEN-1:0] a_q, b_q, wb_data_q;
  logic [2:0]      f3_q;
  logic [6:0]      f7_q;
  logic            imm_q;
  logic [REGW-1:0] rd_q, wb_rd_q;
  logic            alu_en_q, wb_valid_q, timeout_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            ready, accept;

  // A busy alu (possibly left over from an op killed by reset) blocks any new accept.
  assign ready  = !i_rst && !i_alu_busy &&
                  ((state_q == S_IDLE) || ((state_q == S_OUT) && i_wb_ready));
  assign accept = i_valid && ready;

`ifdef ISSUE_FASTPATH_EN
  logic multi_cycle;
  assign multi_cycle = (f3_q == 3'b001) || (f3_q == 3'b101) ||
                       ((f7_q == 7'b0000001) && !imm_q);
`endif

  always_ff @(posedge i_clk_n or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      f3_q       <= '0;
      f7_q       <= '0;
      imm_q      <= 1'b0;
      rd_q       <= '0;
      alu_en_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else if (accept) begin
      a_q        <= i_rs1;
      b_q        <= i_use_imm ? i_imm : i_rs2;
      f3_q       <= i_funct3;
      f7_q       <= i_funct7;
      imm_q      <= i_use_imm;
      rd_q       <= i_rd;
      alu_en_q   <= 1'b1;
      wb_valid_q <= 1'b0;
      wait_cnt_q <= '0;
      state_q    <= S_EXEC;
    end else begin
      case (state_q)
        S_EXEC: begin
`ifdef ISSUE_FASTPATH_EN
          if (!multi_cycle) begin
            wb_data_q  <= i_alu_out;
            wb_rd_q    <= rd_q;
            wb_valid_q <= 1'b1;
            alu_en_q   <= 1'b0;
            state_q    <= S_OUT;
          end else begin
            state_q <= S_WAIT;
          end
`else
          state_q <= S_WAIT;
`endif
        end
        S_WAIT: begin
          if (!i_alu_busy) begin
            wb_data_q  <= i_alu_out;
            wb_rd_q    <= rd_q;
            wb_valid_q <= 1'b1;
            alu_en_q   <= 1'b0;
            state_q    <= S_OUT;
          end else if (wait_cnt_q == CW'(MAX_WAIT - 1)) begin
            timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        S_OUT: begin
          if (i_wb_ready) begin
            wb_valid_q <= 1'b0;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_ready      = ready;
  assign o_alu_a      = a_q;
  assign o_alu_b      = b_q;
  assign o_alu_funct3 = f3_q;
  assign o_alu_funct7 = f7_q;
  assign o_alu_imm    = imm_q;
  assign o_alu_en     = alu_en_q;
  assign o_wb_valid   = wb_valid_q;
  assign o_wb_rd      = wb_rd_q;
  assign o_wb_data    = wb_data_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed scoreboard bench for alu_issue_stage with a multi-cycle alu model.
// Expected latency follows ISSUE_FASTPATH_EN.
module tb_alu_issue_stage;

`ifdef ISSUE_FASTPATH_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, o_ready;
  logic [31:0] rs1, rs2, imm;
  logic        use_imm;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] o_alu_a, o_alu_b;
  logic [2:0]  o_alu_funct3;
  logic [6:0]  o_alu_funct7;
  logic        o_alu_en, o_alu_imm;
  logic        alu_busy;
  logic [31:0] alu_out;
  logic        o_wb_valid, wb_ready;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_timeout;

  typedef struct packed {logic [4:0] rd; logic [31:0] data;} sb_t;
  sb_t sb[$];
  sb_t sb_e;

  int checks = 0;
  int failures = 0;
  int force_lat = 0;
  int rem_cyc = 0;
  int alu_lat;
  bit alu_active = 0;

  alu_issue_stage dut (
    .i_clk_n(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm), .i_use_imm(use_imm),
    .i_funct3(funct3), .i_funct7(funct7), .i_rd(rd),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_funct3(o_alu_funct3),
    .o_alu_funct7(o_alu_funct7), .o_alu_en(o_alu_en), .o_alu_imm(o_alu_imm),
    .i_alu_busy(alu_busy), .i_alu_out(alu_out),
    .o_wb_valid(o_wb_valid), .i_wb_ready(wb_ready), .o_wb_rd(o_wb_rd),
    .o_wb_data(o_wb_data), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Alu model: launches when o_alu_en rises, stays busy for the op's cycle count.
  always @(negedge clk) begin
    if (rem_cyc > 0) begin
      alu_busy = 1'b1;
      rem_cyc--;
    end else begin
      alu_busy = 1'b0;
    end
    if (o_alu_en && !alu_active) begin
      alu_active = 1;
      alu_lat = 0;
      if (o_alu_funct7 == 7'h01 && !o_alu_imm) begin
        alu_lat = 33;
        case (o_alu_funct3)
          3'b100:  alu_out = $signed(o_alu_a) / $signed(o_alu_b);
          3'b110:  alu_out = $signed(o_alu_a) % $signed(o_alu_b);
          default: alu_out = o_alu_a * o_alu_b;
        endcase
      end else begin
        case (o_alu_funct3)
          3'b000:  alu_out = (o_alu_funct7 == 7'h20 && !o_alu_imm) ? o_alu_a - o_alu_b : o_alu_a + o_alu_b;
          3'b001: begin
            alu_out = o_alu_a << o_alu_b[4:0];
            alu_lat = int'(o_alu_b[4:0]);
          end
          default: alu_out = o_alu_a ^ o_alu_b;
        endcase
      end
      rem_cyc = (force_lat > 0) ? force_lat : alu_lat;
    end else if (!o_alu_en) begin
      alu_active = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && o_wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        chk("wb_spurious", 32'(o_wb_valid), 32'd0);
      end else begin
        sb_e = sb.pop_front();
        chk("wb_data", o_wb_data, sb_e.data);
        chk("wb_rd", 32'(o_wb_rd), 32'(sb_e.rd));
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                       input logic ui, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] d, input logic [31:0] exp);
    int n;
    bit acc;
    @(posedge clk); #1;
    rs1 = a; rs2 = b; imm = im; use_imm = ui; funct3 = f3; funct7 = f7; rd = d;
    i_valid = 1'b1;
    n = 0;
    acc = 0;
    while (!acc && n < 200) begin
      @(negedge clk); #1;
      acc = o_ready;
      @(posedge clk);
      n++;
    end
    #1 i_valid = 1'b0;
    chk("accept", 32'(acc), 32'd1);
    if (acc) sb.push_back('{rd: d, data: exp});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || o_wb_valid) && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain", 32'(n < 400), 32'd1);
  endtask

  int  lat, n, en_cyc, busy_cyc;
  bit  stable, hold_ok, no_wb;

  initial begin
    rst = 1'b1; i_valid = 1'b0; rs1 = '0; rs2 = '0; imm = '0; use_imm = 1'b0;
    funct3 = '0; funct7 = '0; rd = '0; wb_ready = 1'b1; alu_busy = 1'b0; alu_out = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_alu_en", 32'(o_alu_en), 32'd0);
    chk("rst_wb_valid", 32'(o_wb_valid), 32'd0);
    chk("rst_wb_data", o_wb_data, 32'd0);
    chk("rst_timeout", 32'(o_timeout), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // ADD: operand drive in EXEC and accept-to-valid latency
    issue(32'd5, 32'd7, 32'd0, 1'b0, 3'b000, 7'h00, 5'd3, 32'd12);
    @(negedge clk); #1;
    chk("add_en", 32'(o_alu_en), 32'd1);
    chk("add_a", o_alu_a, 32'd5);
    chk("add_b", o_alu_b, 32'd7);
    lat = 0;
    while (!o_wb_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk); #1;
    end
    chk("add_lat", 32'(lat), 32'(EXP_LAT));
    chk("add_data", o_wb_data, 32'd12);
    chk("add_rd", 32'(o_wb_rd), 32'd3);
    wait_idle();

    issue(32'd3, 32'd5, 32'd0, 1'b0, 3'b000, 7'h20, 5'd4, 32'hFFFF_FFFE);
    wait_idle();
    issue(32'd1, 32'd0, 32'hFFFF_FFFF, 1'b1, 3'b000, 7'h00, 5'd0, 32'd0);
    @(negedge clk); #1;
    chk("addi_b", o_alu_b, 32'hFFFF_FFFF);
    chk("addi_imm", 32'(o_alu_imm), 32'd1);
    wait_idle();

    // SLLI 31 on a serial shifter: alu inputs must not move while busy
    issue(32'd1, 32'd0, 32'd31, 1'b1, 3'b001, 7'h00, 5'd7, 32'h8000_0000);
    stable = 1; en_cyc = 0; busy_cyc = 0; n = 0;
    do begin
      @(negedge clk); #1;
      if (o_alu_en) begin
        en_cyc++;
        if (o_alu_a !== 32'd1 || o_alu_b !== 32'd31 || o_alu_funct3 !== 3'b001) stable = 0;
      end
      if (alu_busy) busy_cyc++;
      n++;
    end while (!o_wb_valid && n < 100);
    chk("slli_stable", 32'(stable), 32'd1);
    chk("slli_en_cycles", 32'(en_cyc), 32'd33);
    chk("slli_busy_cycles", 32'(busy_cyc), 32'd31);
    wait_idle();

    issue(-32'sd20, 32'd3, 32'd0, 1'b0, 3'b100, 7'h01, 5'd9, -32'sd6);
    wait_idle();
    issue(-32'sd20, 32'd3, 32'd0, 1'b0, 3'b110, 7'h01, 5'd10, -32'sd2);
    wait_idle();
    chk("div_no_timeout", 32'(o_timeout), 32'd0);

    // Consumer stall in OUT, then handshake and new accept on the same edge
    wb_ready = 1'b0;
    issue(32'd10, 32'd20, 32'd0, 1'b0, 3'b000, 7'h00, 5'd11, 32'd30);
    n = 0;
    while (!o_wb_valid && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    rs1 = 32'd100; rs2 = 32'd1; use_imm = 1'b0; funct3 = 3'b000; funct7 = 7'h00; rd = 5'd12;
    i_valid = 1'b1;
    hold_ok = 1;
    repeat (5) begin
      if (!o_wb_valid || o_wb_data !== 32'd30 || o_wb_rd !== 5'd11 || o_ready !== 1'b0) hold_ok = 0;
      @(posedge clk);
      @(negedge clk); #1;
    end
    chk("stall_hold", 32'(hold_ok), 32'd1);
    @(posedge clk); #1 wb_ready = 1'b1;
    @(negedge clk); #1;
    chk("b2b_ready", 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    i_valid = 1'b0;
    sb.push_back('{rd: 5'd12, data: 32'd101});
    @(negedge clk); #1;
    chk("b2b_wb_drop", 32'(o_wb_valid), 32'd0);
    chk("b2b_en", 32'(o_alu_en), 32'd1);
    chk("b2b_a", o_alu_a, 32'd100);
    wait_idle();

    // Reset in WAIT: outputs clear at once, no wb entry, accept blocked while alu busy
    issue(-32'sd20, 32'd3, 32'd0, 1'b0, 3'b100, 7'h01, 5'd14, -32'sd6);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_en", 32'(o_alu_en), 32'd0);
    chk("arst_a", o_alu_a, 32'd0);
    chk("arst_f3", 32'(o_alu_funct3), 32'd0);
    chk("arst_wb_valid", 32'(o_wb_valid), 32'd0);
    chk("arst_ready", 32'(o_ready), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk); #1;
    chk("arst_busy_block", 32'(o_ready), 32'd0);
    no_wb = 1; n = 0;
    while (alu_busy && n < 100) begin
      if (o_wb_valid) no_wb = 0;
      @(negedge clk); #1;
      n++;
    end
    chk("arst_no_wb", 32'(no_wb), 32'd1);
    chk("arst_ready_after", 32'(o_ready), 32'd1);

    // Busy beyond MAX_WAIT raises a sticky timeout
    force_lat = 70;
    issue(-32'sd20, 32'd3, 32'd0, 1'b0, 3'b100, 7'h01, 5'd13, -32'sd6);
    wait_idle();
    force_lat = 0;
    chk("timeout_set", 32'(o_timeout), 32'd1);
    issue(32'd1, 32'd1, 32'd0, 1'b0, 3'b000, 7'h00, 5'd1, 32'd2);
    wait_idle();
    chk("timeout_sticky", 32'(o_timeout), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    #1 chk("timeout_clear", 32'(o_timeout), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
